// File: rtl/rx_fifo_a_if.sv
// Channel A receive FIFO bus: receiver character handoff, RHR read strobe and status.
// The master modport is the receiver/CPU side, the slave modport is the FIFO.
interface rx_fifo_a_if #(
    parameter int unsigned WIDTH = 8
);
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_perr;
    logic             rx_ferr;
    logic             rx_break;
    logic             cs;
    logic             rw;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             rxrdy;
    logic             ffull;
    logic             ovr_err;
    logic             perr;
    logic             ferr;
    logic             rbrk;

    modport master (
        output rx_valid, rx_data, rx_perr, rx_ferr, rx_break, cs, rw, clr_ovr,
        input  data_out, rxrdy, ffull, ovr_err, perr, ferr, rbrk
    );

    modport slave (
        input  rx_valid, rx_data, rx_perr, rx_ferr, rx_break, cs, rw, clr_ovr,
        output data_out, rxrdy, ffull, ovr_err, perr, ferr, rbrk
    );
endinterface

// File: rtl/rx_fifo_a.sv
// Channel A receive holding FIFO feeding RxRDYA/FFULLA and the overrun status.
// Define RX_FIFO_ERR_EN to store per-character break/framing/parity status.
module rx_fifo_a #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 8
) (
    input logic        clk,
    input logic        reset,
    rx_fifo_a_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RX_FIFO_ERR_EN
    localparam int unsigned SW = WIDTH + 3;
`else
    localparam int unsigned SW = WIDTH;
`endif

    typedef logic [SW-1:0] slot_t;

    slot_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0]  count, count_next;
    logic           rd_act, rd_act_q, pop, pop_ok, push, ovr_set, full, empty;
    slot_t          wr_slot, head_next;
    logic [WIDTH-1:0] data_q;
    logic           rxrdy_q, ffull_q, ovr_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef RX_FIFO_ERR_EN
    assign wr_slot = {bus.rx_break, bus.rx_ferr, bus.rx_perr, bus.rx_data};
`else
    assign wr_slot = bus.rx_data;
`endif

    always_comb begin
        rd_act  = bus.cs & bus.rw;
        pop     = rd_act_q & ~rd_act;
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        pop_ok  = pop & ~empty;
        push    = bus.rx_valid & (~full | pop_ok);
        ovr_set = bus.rx_valid & full & ~pop_ok;

        count_next = count;
        if (push && !pop_ok)
            count_next = count + CW'(1);
        else if (pop_ok && !push)
            count_next = count - CW'(1);

        rd_next = pop_ok ? ptr_inc(rd_ptr) : rd_ptr;
        // Bypass the incoming character when it lands in the slot becoming head,
        // so data_out turns valid on the same edge as rxrdy.
        head_next = (push && (wr_ptr == rd_next)) ? wr_slot : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_slot;
    end

`ifdef RX_FIFO_ERR_EN
    logic perr_q, ferr_q, rbrk_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_act_q <= 1'b0;
            rxrdy_q  <= 1'b0;
            ffull_q  <= 1'b0;
            ovr_q    <= 1'b0;
            data_q   <= '0;
`ifdef RX_FIFO_ERR_EN
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            rbrk_q   <= 1'b0;
`endif
        end else begin
            rd_act_q <= rd_act;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr  <= rd_next;
            count   <= count_next;
            rxrdy_q <= (count_next != '0);
            ffull_q <= (count_next == CW'(DEPTH));
            if (ovr_set)
                ovr_q <= 1'b1;
            else if (bus.clr_ovr)
                ovr_q <= 1'b0;
            // Head outputs hold their last value while the FIFO is empty.
            if (count_next != '0) begin
                data_q <= head_next[WIDTH-1:0];
`ifdef RX_FIFO_ERR_EN
                perr_q <= head_next[WIDTH];
                ferr_q <= head_next[WIDTH+1];
                rbrk_q <= head_next[WIDTH+2];
`endif
            end
        end
    end

    assign bus.data_out = data_q;
    assign bus.rxrdy    = rxrdy_q;
    assign bus.ffull    = ffull_q;
    assign bus.ovr_err  = ovr_q;
`ifdef RX_FIFO_ERR_EN
    assign bus.perr = perr_q;
    assign bus.ferr = ferr_q;
    assign bus.rbrk = rbrk_q;
`else
    logic unused_err;
    assign unused_err = ^{bus.rx_perr, bus.rx_ferr, bus.rx_break};
    assign bus.perr = 1'b0;
    assign bus.ferr = 1'b0;
    assign bus.rbrk = 1'b0;
`endif
endmodule
